cell_plotter: RTL and testbench

CELL_PLOTTER -- requirements
Module: cell_plotter

---
 rtl/cell_plot_pkg.sv | 31 +++
 rtl/cell_fifo.sv | 67 ++++++
 rtl/cell_plotter.sv | 192 +++++++++++++++++++
 tb/tb_cell_plotter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_plot_pkg.sv
// Shared types and constants for the cell plotter: FSM encoding, FIFO sizing,
// default grid geometry and the stored entry layout.
package cell_plot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_CNT_W = 3;

  localparam int DEF_CELL_SIZE = 4;
  localparam int DEF_GRID_W    = 16;
  localparam int DEF_GRID_H    = 16;

  // y is stored as 7 bits: only in-range rows are ever buffered, and every
  // in-range row fits the 7-bit VGA row space.
  localparam int ENT_X_W     = 8;
  localparam int ENT_Y_W     = 7;
  localparam int ENT_COLOR_W = 3;

  typedef struct packed {
    logic [ENT_X_W-1:0]     x;
    logic [ENT_Y_W-1:0]     y;
    logic [ENT_COLOR_W-1:0] color;
  } entry_t;

endpackage

// File: rtl/cell_fifo.sv
// Four-entry synchronous FIFO of cell-update entries with full/empty flags.
module cell_fifo
  import cell_plot_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam logic [FIFO_PTR_W-1:0] PTR_ONE  = FIFO_PTR_W'(1);
  localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);
  localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);

  entry_t                  mem_q [FIFO_DEPTH];
  entry_t                  mem_d [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0]   count_q, count_d;
  logic                    push_ok, pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; push+pop keeps count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Register FIFO state; synchronous reset empties the buffer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cell_plotter.sv
// Cell plotter: buffers cell updates and expands each into a CELL_SIZE square
// of VGA pixel writes, with a whole-grid blanking sweep on request.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no pixel output; start a clear (priority) or pop the next cell
// ST_DRAW  | one cell pixel per cycle, x fastest; chains cells with no gap
// ST_CLEAR | one black pixel per cycle across the grid area, row-major
module cell_plotter
  import cell_plot_pkg::*;
#(
  parameter int CELL_SIZE = DEF_CELL_SIZE,
  parameter int GRID_W    = DEF_GRID_W,
  parameter int GRID_H    = DEF_GRID_H
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cell_valid,
  output logic       cell_ready,
  input  logic [7:0] cell_x,
  input  logic [7:0] cell_y,
  input  logic [2:0] cell_color,
  input  logic       clear_req,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  localparam logic [7:0] CELL_X   = 8'(CELL_SIZE);
  localparam logic [6:0] CELL_Y   = 7'(CELL_SIZE);
  localparam logic [7:0] CELL_XM1 = 8'(CELL_SIZE - 1);
  localparam logic [6:0] CELL_YM1 = 7'(CELL_SIZE - 1);
  localparam logic [7:0] GRID_W_L = 8'(GRID_W);
  localparam logic [7:0] GRID_H_L = 8'(GRID_H);
  localparam logic [7:0] CLR_XMAX = 8'(GRID_W * CELL_SIZE - 1);
  localparam logic [6:0] CLR_YMAX = 7'(GRID_H * CELL_SIZE - 1);

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [7:0] px_q, px_d;
  logic [6:0] py_q, py_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [2:0] colour_q, colour_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic       in_range, clear_eff;
  entry_t     fifo_din, head;

  // Out-of-grid entries are still handshaken but never reach the FIFO.
  assign cell_ready = reset_n & ~fifo_full;
  assign in_range   = (cell_x < GRID_W_L) && (cell_y < GRID_H_L);
  assign fifo_push  = cell_valid & cell_ready & in_range;
  assign fifo_din   = '{x: cell_x, y: cell_y[6:0], color: cell_color};

  // A request in the current cycle acts like an already-pending clear.
  assign clear_eff  = pending_q | (clear_req & (state_q != ST_CLEAR));

  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

  cell_fifo u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM next-state, pixel counters and registered VGA outputs.
  always_comb begin
    state_d      = state_q;
    pending_d    = clear_eff;
    px_d         = px_q;
    py_d         = py_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_eff) begin
          state_d   = ST_CLEAR;
          pending_d = 1'b0;
          px_d      = '0;
          py_d      = '0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          base_x_d = head.x * CELL_X;
          base_y_d = head.y * CELL_Y;
          colour_d = head.color;
          px_d     = '0;
          py_d     = '0;
          state_d  = ST_DRAW;
        end
      end
      ST_DRAW: begin
        vga_plot_d   = 1'b1;
        vga_x_d      = base_x_q + px_q;
        vga_y_d      = base_y_q + py_q;
        vga_colour_d = colour_q;
        if (px_q == CELL_XM1) begin
          px_d = '0;
          if (py_q == CELL_YM1) begin
            py_d = '0;
            if (clear_eff) begin
              state_d   = ST_CLEAR;
              pending_d = 1'b0;
            end else if (!fifo_empty) begin
              fifo_pop = 1'b1;
              base_x_d = head.x * CELL_X;
              base_y_d = head.y * CELL_Y;
              colour_d = head.color;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            py_d = py_q + 7'd1;
          end
        end else begin
          px_d = px_q + 8'd1;
        end
      end
      ST_CLEAR: begin
        vga_plot_d   = 1'b1;
        vga_x_d      = px_q;
        vga_y_d      = py_q;
        vga_colour_d = 3'b000;
        if (px_q == CLR_XMAX) begin
          px_d = '0;
          if (py_q == CLR_YMAX) begin
            py_d    = '0;
            state_d = ST_IDLE;
          end else begin
            py_d = py_q + 7'd1;
          end
        end else begin
          px_d = px_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register all plotter state; reset aborts any draw or clear at once.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      colour_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      px_q         <= px_d;
      py_q         <= py_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter (CELL_SIZE=4, 16x16 grid): a table of
// single-entry vectors plus hand-written multi-cycle sequences.
module tb_cell_plotter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cell_valid = 1'b0;
  logic [7:0] cell_x = '0;
  logic [7:0] cell_y = '0;
  logic [2:0] cell_color = '0;
  logic       clear_req = 1'b0;
  logic       cell_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  cell_plotter #(.CELL_SIZE(4), .GRID_W(16), .GRID_H(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cell_color (cell_color),
    .clear_req  (clear_req),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q_x[$];
  int q_y[$];
  int q_c[$];
  int q_t[$];
  int first_block = -1;

  // Cycle counter and pixel log, sampled 1 ns after each rising edge.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (vga_plot) begin
      q_x.push_back(int'(vga_x));
      q_y.push_back(int'(vga_y));
      q_c.push_back(int'(vga_colour));
      q_t.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    q_x.delete();
    q_y.delete();
    q_c.delete();
    q_t.delete();
  endtask

  function automatic int cell_errs(input int start, input int bx, input int by, input int col);
    int e = 0;
    for (int i = 0; i < 16; i++) begin
      int j = start + i;
      if (j >= q_x.size()) e++;
      else if (q_x[j] != bx + (i % 4) || q_y[j] != by + (i / 4) || q_c[j] != col) e++;
    end
    return e;
  endfunction

  function automatic int clear_errs(input int start);
    int e = 0;
    for (int i = 0; i < 4096; i++) begin
      int j = start + i;
      if (j >= q_x.size()) e++;
      else if (q_x[j] != (i % 64) || q_y[j] != (i / 64) || q_c[j] != 0) e++;
    end
    return e;
  endfunction

  function automatic int gap_errs();
    int e = 0;
    for (int i = 1; i < q_t.size(); i++) begin
      if (q_t[i] - q_t[i-1] != 1) e++;
    end
    return e;
  endfunction

  // Offer one entry (valid held until it transfers); returns the cycle
  // number of the accepting edge.
  task automatic send_entry(input int x, input int y, input int c, input int idx, output int acc);
    int n = 0;
    cell_valid = 1'b1;
    cell_x     = 8'(x);
    cell_y     = 8'(y);
    cell_color = 3'(c);
    while (!cell_ready && n < 400) begin
      if (first_block < 0) first_block = idx;
      @(negedge clock);
      n++;
    end
    chk($sformatf("send%0d_ready", idx), int'(cell_ready), 1);
    @(negedge clock);
    acc        = cyc;
    cell_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clock);
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_plots(input int cnt, input int budget, input string name);
    int n = 0;
    while (q_x.size() < cnt && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_reached"}, q_x.size(), cnt);
  endtask

  typedef struct {
    int cx;
    int cy;
    int col;
    int n_exp;
    int x0;
    int y0;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int acc;
    vecs[0] = '{cx: 2,   cy: 3,   col: 7, n_exp: 16, x0: 8,  y0: 12};
    vecs[1] = '{cx: 0,   cy: 0,   col: 7, n_exp: 16, x0: 0,  y0: 0};
    vecs[2] = '{cx: 15,  cy: 15,  col: 7, n_exp: 16, x0: 60, y0: 60};
    vecs[3] = '{cx: 5,   cy: 1,   col: 0, n_exp: 16, x0: 20, y0: 4};
    vecs[4] = '{cx: 16,  cy: 0,   col: 7, n_exp: 0,  x0: 0,  y0: 0};
    vecs[5] = '{cx: 0,   cy: 16,  col: 7, n_exp: 0,  x0: 0,  y0: 0};
    vecs[6] = '{cx: 255, cy: 200, col: 7, n_exp: 0,  x0: 0,  y0: 0};

    // Reset state, with valid offered so ready must be masked by reset.
    cell_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_plot",   int'(vga_plot),   0);
    chk("rst_x",      int'(vga_x),      0);
    chk("rst_y",      int'(vga_y),      0);
    chk("rst_colour", int'(vga_colour), 0);
    chk("rst_busy",   int'(busy),       0);
    chk("rst_ready",  int'(cell_ready), 0);
    cell_valid = 1'b0;
    reset_n    = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", int'(cell_ready), 1);
    chk("post_rst_nplots", q_x.size(), 0);

    // Table of single entries from idle.
    for (int v = 0; v < 7; v++) begin
      clear_log();
      send_entry(vecs[v].cx, vecs[v].cy, vecs[v].col, 100 + v, acc);
      wait_idle(100, $sformatf("v%0d", v));
      repeat (3) @(negedge clock);
      chk($sformatf("v%0d_nplots", v), q_x.size(), vecs[v].n_exp);
      if (vecs[v].n_exp > 0) begin
        chk($sformatf("v%0d_pix", v), cell_errs(0, vecs[v].x0, vecs[v].y0, vecs[v].col), 0);
        chk($sformatf("v%0d_latency", v), q_t[0] - acc, 2);
        chk($sformatf("v%0d_gaps", v), gap_errs(), 0);
      end
      chk($sformatf("v%0d_busy", v), int'(busy), 0);
    end

    // Clear from idle: full 64x64 black sweep.
    clear_log();
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    wait_idle(5000, "clr");
    repeat (3) @(negedge clock);
    chk("clr_nplots", q_x.size(), 4096);
    chk("clr_pix",    clear_errs(0), 0);
    chk("clr_gaps",   gap_errs(), 0);

    // Six entries back-to-back; ready must drop once four are buffered.
    clear_log();
    first_block = -1;
    for (int k = 0; k < 6; k++) send_entry(4 * k / 4, 0, 7, k, acc);
    wait_idle(300, "six");
    chk("six_block_idx", first_block, 5);
    chk("six_nplots", q_x.size(), 96);
    chk("six_gaps",   gap_errs(), 0);
    begin
      int e = 0;
      for (int k = 0; k < 6; k++) e += cell_errs(16 * k, 4 * k, 0, 7);
      chk("six_pix", e, 0);
    end

    // Out-of-range entry followed by a valid one.
    clear_log();
    first_block = 1000;
    send_entry(16, 0, 7, 200, acc);
    send_entry(0, 0, 7, 201, acc);
    wait_idle(100, "oor");
    chk("oor_nplots", q_x.size(), 16);
    chk("oor_pix",    cell_errs(0, 0, 0, 7), 0);

    // Clear requested on the 5th cell pixel; second request during clear.
    clear_log();
    send_entry(1, 1, 7, 300, acc);
    wait_plots(5, 50, "mid5");
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    wait_plots(116, 300, "inclr");
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    wait_idle(6000, "midclr");
    repeat (20) @(negedge clock);
    chk("midclr_nplots", q_x.size(), 16 + 4096);
    chk("midclr_cell",   cell_errs(0, 4, 4, 7), 0);
    chk("midclr_clear",  clear_errs(16), 0);
    chk("midclr_gaps",   gap_errs(), 0);
    chk("midclr_busy",   int'(busy), 0);

    // Reset on the 8th pixel with two entries buffered.
    clear_log();
    send_entry(0, 0, 7, 400, acc);
    send_entry(1, 0, 7, 401, acc);
    send_entry(2, 0, 7, 402, acc);
    wait_plots(8, 50, "rst8");
    reset_n = 1'b0;
    @(negedge clock);
    chk("rstmid_plot",  int'(vga_plot),   0);
    chk("rstmid_busy",  int'(busy),       0);
    chk("rstmid_ready", int'(cell_ready), 0);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("rstmid_nplots", q_x.size(), 8);
    chk("rstmid_busy2",  int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
